// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the iterative restoring divider.
//   SEQ_DIV_DVD_W : default dividend / quotient width (also the step count)
//   SEQ_DIV_DVS_W : default divisor / remainder width
//   SEQ_DIV_CNT_W : step counter width for the default dividend width
//   state_t       : controller states, visible to checkers through the
//                   top module's internal 'state' signal
package seq_div_pkg;

    localparam int SEQ_DIV_DVD_W = 8;
    localparam int SEQ_DIV_DVS_W = 4;
    localparam int SEQ_DIV_CNT_W = $clog2(SEQ_DIV_DVD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   part_rem : in  partial remainder (DVS_W+1 bits)
//   dvd_bit  : in  next dividend bit, shifted in at the LSB
//   divisor  : in  divisor
//   next_rem : out partial remainder after the step
//   q_bit    : out quotient bit produced by the step
module div_step #(
    parameter int DVS_W = 4
) (
    input  logic [DVS_W:0]   part_rem,
    input  logic             dvd_bit,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   next_rem,
    output logic             q_bit
);

    logic [DVS_W+1:0] shifted;
    logic [DVS_W+1:0] dvs_ext;

    // With a nonzero divisor the partial remainder stays below the divisor,
    // so dropping the top bit of either branch loses nothing. With a zero
    // divisor the value just accumulates the dividend's low bits, which is
    // exactly the defined remainder for that case.
    always_comb begin
        shifted  = {part_rem, dvd_bit};
        dvs_ext  = {2'b00, divisor};
        q_bit    = (shifted >= dvs_ext);
        next_rem = q_bit ? (DVS_W+1)'(shifted - dvs_ext) : (DVS_W+1)'(shifted);
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIV_ZERO_FAST_EN (zero divisor completes in one
// cycle and is flagged on div_zero).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while ready=1
//   dividend   : DVD_W-bit dividend, captured on the accepting edge
//   divisor    : DVS_W-bit divisor, captured on the accepting edge
//   ready      : request can be accepted this cycle (from state only)
//   done       : one-cycle completion pulse, results valid from then on
//   quotient   : DVD_W-bit result, held until the next completion
//   remainder  : DVS_W-bit result, held until the next completion
//   div_zero   : (macro builds only) last completed divisor was zero
// Handshake: a request is accepted on any rising edge where start=1 and
// ready=1 (IDLE or DONE); start is ignored while ready=0, and operand changes
// after the accepting edge have no effect.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int DVD_W = SEQ_DIV_DVD_W,
    parameter int DVS_W = SEQ_DIV_DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder
`ifdef SEQ_DIV_ZERO_FAST_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after DVD_W steps this register holds the quotient.
    logic [DVD_W-1:0] dvd_q;
    logic [DVS_W-1:0] dvs_q;
    logic [DVS_W:0]   part_rem;
    logic [DVS_W:0]   next_rem;
    logic             q_bit;
    logic             accept;
    logic             zero_fast;

    div_step #(.DVS_W(DVS_W)) u_step (
        .part_rem (part_rem),
        .dvd_bit  (dvd_q[DVD_W-1]),
        .divisor  (dvs_q),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    assign accept = start && ready;

`ifdef SEQ_DIV_ZERO_FAST_EN
    assign zero_fast = (divisor == '0);
`else
    assign zero_fast = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = zero_fast ? DONE : RUN;
            end
            RUN: begin
                ready = 1'b0;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = zero_fast ? DONE : RUN;
                else       state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            part_rem  <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIV_ZERO_FAST_EN
            div_zero  <= 1'b0;
`endif
        end else if (accept) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            part_rem <= '0;
            cnt      <= '0;
`ifdef SEQ_DIV_ZERO_FAST_EN
            if (zero_fast) begin
                quotient  <= '1;
                remainder <= dividend[DVS_W-1:0];
                div_zero  <= 1'b1;
            end
`endif
        end else if (state == RUN) begin
            dvd_q    <= {dvd_q[DVD_W-2:0], q_bit};
            part_rem <= next_rem;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST) begin
                quotient  <= {dvd_q[DVD_W-2:0], q_bit};
                remainder <= next_rem[DVS_W-1:0];
`ifdef SEQ_DIV_ZERO_FAST_EN
                // RUN is only entered with a nonzero divisor in this build.
                div_zero  <= 1'b0;
`endif
            end
        end
    end

endmodule
